// File: rtl/matmul_pkg.sv
// Shared types for the matrix-multiply controller and its dot-product engines.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package matmul_pkg;

    // Dot-product engine sequencing states
    typedef enum logic [1:0] {
        DP_IDLE  = 2'd0,
        DP_FETCH = 2'd1,
        DP_DRAIN = 2'd2,
        DP_DONE  = 2'd3
    } dp_state_t;

    // Matmul controller sequencing states
    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_ISSUE = 2'd1,
        MM_WAIT  = 2'd2,
        MM_END   = 2'd3
    } mm_state_t;

    // Row/column position tracked by the controller while walking a matrix
    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
    } mm_coord_t;

    // Width of an element index; never zero so a 1-element vector still has a counter
    function automatic int unsigned idx_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/dot_product_engine_mac_unit.sv
// Signed multiply-accumulate with synchronous clear; wraps modulo 2^(2*DATA_WIDTH).
// Latency: product folded into acc on the clock edge where enable is high.
// Backpressure: none; caller controls enable.
module mac_unit #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          enable,
    input  logic signed [DATA_WIDTH-1:0]  a,
    input  logic signed [DATA_WIDTH-1:0]  b,
    output logic [2*DATA_WIDTH-1:0]       acc
);

    localparam int ACC_W = 2 * DATA_WIDTH;

    // Operands are sign-extended to full width so the product is exact before wrapping
    logic signed [ACC_W-1:0] prod;
    assign prod = ACC_W'(a) * ACC_W'(b);

    // Accumulator: clear wins over enable; no saturation, plain two's-complement wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// Computes one signed dot product of a weight row and the input vector from two read ports.
// Latency: dp_done pulses VEC_LEN+2 cycles after the accepted dp_start.
// Backpressure: none; dp_start outside IDLE is dropped, busy tells the controller when to wait.
module dot_product_engine
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int VEC_LEN    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dp_start,
    input  logic [ADDR_WIDTH-1:0]         dp_weight_base_addr,
    output logic                          dp_done,
    output logic [2*DATA_WIDTH-1:0]       dp_result,
    output logic                          w_rd_en,
    output logic [ADDR_WIDTH-1:0]         w_rd_addr,
    input  logic signed [DATA_WIDTH-1:0]  w_rd_data,
    output logic                          x_rd_en,
    output logic [ADDR_WIDTH-1:0]         x_rd_addr,
    input  logic signed [DATA_WIDTH-1:0]  x_rd_data,
    output logic                          busy
);

    localparam int                IDX_W    = idx_width(VEC_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VEC_LEN - 1);

    dp_state_t                state, state_d;
    logic [ADDR_WIDTH-1:0]    base_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     rd_vld_q;
    logic [2*DATA_WIDTH-1:0]  acc;
    logic [2*DATA_WIDTH-1:0]  result_q;
    logic                     accept;
    logic                     fetch;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DP_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and per-state strobes; only IDLE listens to dp_start
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        fetch   = 1'b0;
        case (state)
            DP_IDLE: begin
                if (dp_start) begin
                    accept  = 1'b1;
                    state_d = DP_FETCH;
                end
            end
            DP_FETCH: begin
                fetch = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DP_DRAIN;
                end
            end
            DP_DRAIN: state_d = DP_DONE;
            DP_DONE:  state_d = DP_IDLE;
            default:  state_d = DP_IDLE;
        endcase
    end

    // Request bookkeeping: base latch, element index, and read-latency valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= fetch;
            if (accept) begin
                base_q <= dp_weight_base_addr;
                idx_q  <= '0;
            end else if (fetch) begin
                idx_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Result holding register: captures the final sum as DONE is left so it persists in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (state == DP_DONE) begin
            result_q <= acc;
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (rd_vld_q),
        .a      (w_rd_data),
        .b      (x_rd_data),
        .acc    (acc)
    );

    // Read ports are driven straight from state so reset silences them immediately
    assign w_rd_en   = fetch;
    assign x_rd_en   = fetch;
    assign w_rd_addr = base_q + ADDR_WIDTH'(idx_q);
    assign x_rd_addr = ADDR_WIDTH'(idx_q);

    assign dp_done   = (state == DP_DONE);
    assign busy      = (state != DP_IDLE);
    // The accumulator is final on DONE entry; show it then, and the held copy afterwards
    assign dp_result = (state == DP_DONE) ? acc : result_q;

endmodule

// File: tb/tb_dot_product_engine.sv
module tb_dot_product_engine;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int VL  = 8;
    localparam int MEM = 1 << AW;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  dp_start;
    logic [AW-1:0]         dp_weight_base_addr;
    logic                  dp_done;
    logic [2*DW-1:0]       dp_result;
    logic                  w_rd_en, x_rd_en;
    logic [AW-1:0]         w_rd_addr, x_rd_addr;
    logic signed [DW-1:0]  w_rd_data = '0;
    logic signed [DW-1:0]  x_rd_data = '0;
    logic                  busy;

    logic signed [DW-1:0]  w_mem [MEM];
    logic signed [DW-1:0]  x_mem [MEM];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle observation log, index = cycle number relative to the run start
    logic            lg_busy [64];
    logic            lg_done [64];
    logic            lg_wen  [64];
    logic            lg_xen  [64];
    logic [AW-1:0]   lg_wa   [64];
    logic [AW-1:0]   lg_xa   [64];
    logic [2*DW-1:0] lg_res  [64];

    always #5 clk = ~clk;

    dot_product_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dp_start            (dp_start),
        .dp_weight_base_addr (dp_weight_base_addr),
        .dp_done             (dp_done),
        .dp_result           (dp_result),
        .w_rd_en             (w_rd_en),
        .w_rd_addr           (w_rd_addr),
        .w_rd_data           (w_rd_data),
        .x_rd_en             (x_rd_en),
        .x_rd_addr           (x_rd_addr),
        .x_rd_data           (x_rd_data),
        .busy                (busy)
    );

    // Synchronous-read memories, one cycle of latency
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
        if (x_rd_en) x_rd_data <= x_mem[x_rd_addr];
    end

    // Reference: plain sum of products, wrapped to 2*DW bits
    function automatic logic [2*DW-1:0] ref_dot(input int b);
        longint s = 0;
        for (int i = 0; i < VL; i++)
            s += longint'(w_mem[(b + i) % MEM]) * longint'(x_mem[i]);
        return s[2*DW-1:0];
    endfunction

    function automatic int first_done(input int n);
        for (int c = 0; c < n; c++) if (lg_done[c] === 1'b1) return c;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) if (lg_done[c] === 1'b1) k++;
        return k;
    endfunction

    function automatic int count_wen(input int n);
        int k = 0;
        for (int c = 0; c < n; c++) if (lg_wen[c] === 1'b1) k++;
        return k;
    endfunction

    // Drive n cycles: start/reset per cycle from masks, sample outputs mid-cycle
    task automatic run_cycles(input int n, input logic [63:0] start_mask,
                              input logic [63:0] rst_mask, input logic [AW-1:0] b);
        dp_weight_base_addr = b;
        for (int c = 0; c < n; c++) begin
            dp_start = start_mask[c];
            rst_n    = ~rst_mask[c];
            @(negedge clk);
            lg_busy[c] = busy;
            lg_done[c] = dp_done;
            lg_wen[c]  = w_rd_en;
            lg_xen[c]  = x_rd_en;
            lg_wa[c]   = w_rd_addr;
            lg_xa[c]   = x_rd_addr;
            lg_res[c]  = dp_result;
            @(posedge clk);
            #1;
        end
        dp_start = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic load_basic();
        for (int i = 0; i < MEM; i++) begin
            w_mem[i] = '0;
            x_mem[i] = '0;
        end
        for (int i = 0; i < VL; i++) begin
            w_mem[i] = DW'(i + 1);
            x_mem[i] = 16'sd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dp_start = 1'b0;
        dp_weight_base_addr = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dp_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b exp=0", dp_done); end
        n_checks++; if (dp_result !== '0)  begin n_fail++; $display("FAIL reset_result got=%h exp=0", dp_result); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if ({w_rd_en, x_rd_en} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_en got=%b%b exp=00", w_rd_en, x_rd_en); end
        n_checks++; if ({w_rd_addr, x_rd_addr} !== '0) begin n_fail++; $display("FAIL reset_addr got=%h/%h exp=0/0", w_rd_addr, x_rd_addr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycles(3, 64'h0, 64'h0, '0);
        n_checks++; if (count_done(3) != 0 || lg_busy[2] !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset done=%0d busy=%b exp=0/0", count_done(3), lg_busy[2]); end
    endtask

    task automatic test_basic();
        logic [2*DW-1:0] exp;
        load_basic();
        exp = ref_dot(0);
        run_cycles(13, 64'h1, 64'h0, '0);
        n_checks++; if (first_done(13) != 10) begin n_fail++; $display("FAIL basic_latency got=%0d exp=10", first_done(13)); end
        n_checks++; if (count_done(13) != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", count_done(13)); end
        n_checks++; if (lg_res[10] !== exp) begin n_fail++; $display("FAIL basic_result got=%0d exp=%0d", $signed(lg_res[10]), $signed(exp)); end
        n_checks++; if (lg_res[12] !== exp) begin n_fail++; $display("FAIL basic_result_hold got=%0d exp=%0d", $signed(lg_res[12]), $signed(exp)); end
        for (int c = 0; c < 13; c++) begin
            n_checks++;
            if (lg_busy[c] !== (c >= 1 && c <= 10)) begin n_fail++; $display("FAIL basic_busy cycle=%0d got=%b exp=%b", c, lg_busy[c], (c >= 1 && c <= 10)); end
            n_checks++;
            if ({lg_wen[c], lg_xen[c]} !== {2{(c >= 1 && c <= VL)}}) begin n_fail++; $display("FAIL basic_rd_en cycle=%0d got=%b%b", c, lg_wen[c], lg_xen[c]); end
        end
    endtask

    task automatic test_base_offset();
        logic [2*DW-1:0] exp;
        for (int i = 0; i < VL; i++) begin
            w_mem[8 + i] = -16'sd2;
            x_mem[i]     = DW'(i + 3);
        end
        exp = ref_dot(8);
        run_cycles(13, 64'h1, 64'h0, AW'(8));
        for (int c = 1; c <= VL; c++) begin
            n_checks++;
            if (lg_wa[c] !== AW'(8 + c - 1) || lg_xa[c] !== AW'(c - 1)) begin
                n_fail++; $display("FAIL offset_addr cycle=%0d got=%0d/%0d exp=%0d/%0d", c, lg_wa[c], lg_xa[c], 8 + c - 1, c - 1);
            end
        end
        n_checks++; if (lg_done[10] !== 1'b1 || lg_res[10] !== exp) begin n_fail++; $display("FAIL offset_result done=%b got=%h exp=%h", lg_done[10], lg_res[10], exp); end
    endtask

    task automatic test_extreme();
        logic [2*DW-1:0] exp;
        for (int i = 0; i < VL; i++) begin
            w_mem[i] = -16'sd32768;
            x_mem[i] = -16'sd32768;
        end
        exp = ref_dot(0);
        run_cycles(13, 64'h1, 64'h0, '0);
        n_checks++; if (lg_done[10] !== 1'b1 || lg_res[10] !== exp) begin n_fail++; $display("FAIL extreme_wrap done=%b got=%h exp=%h", lg_done[10], lg_res[10], exp); end
    endtask

    task automatic test_ignore_start();
        logic [2*DW-1:0] exp;
        load_basic();
        exp = ref_dot(0);
        run_cycles(14, 64'h409, 64'h0, '0);
        n_checks++; if (count_done(14) != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", count_done(14)); end
        n_checks++; if (first_done(14) != 10) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=10", first_done(14)); end
        n_checks++; if (lg_res[10] !== exp) begin n_fail++; $display("FAIL ignore_result got=%0d exp=%0d", $signed(lg_res[10]), $signed(exp)); end
        n_checks++; if (count_wen(14) != VL) begin n_fail++; $display("FAIL ignore_refetch got=%0d exp=%0d", count_wen(14), VL); end
        n_checks++; if (lg_busy[11] !== 1'b0) begin n_fail++; $display("FAIL ignore_restart busy11=%b exp=0", lg_busy[11]); end
    endtask

    task automatic test_mid_reset();
        logic [2*DW-1:0] exp;
        load_basic();
        exp = ref_dot(0);
        run_cycles(8, 64'h1, 64'h10, '0);
        n_checks++; if (lg_wen[3] !== 1'b1) begin n_fail++; $display("FAIL midrst_running got=%b exp=1", lg_wen[3]); end
        n_checks++; if ({lg_wen[4], lg_xen[4]} !== 2'b00) begin n_fail++; $display("FAIL midrst_rd_en got=%b%b exp=00", lg_wen[4], lg_xen[4]); end
        n_checks++; if (lg_res[4] !== '0) begin n_fail++; $display("FAIL midrst_result got=%h exp=0", lg_res[4]); end
        n_checks++; if (count_done(8) != 0 || lg_busy[7] !== 1'b0) begin n_fail++; $display("FAIL midrst_abandon done=%0d busy=%b exp=0/0", count_done(8), lg_busy[7]); end
        run_cycles(13, 64'h1, 64'h0, '0);
        n_checks++; if (first_done(13) != 10 || lg_res[10] !== exp) begin n_fail++; $display("FAIL midrst_restart lat=%0d got=%0d exp=10/%0d", first_done(13), $signed(lg_res[10]), $signed(exp)); end
    endtask

    task automatic test_rows();
        logic [2*DW-1:0] exp_q[$];
        logic [2*DW-1:0] got_q[$];
        int d;
        for (int r = 0; r < VL; r++)
            for (int i = 0; i < VL; i++) w_mem[VL * r + i] = DW'(r + 1);
        for (int i = 0; i < VL; i++) x_mem[i] = 16'sd1;
        for (int r = 0; r < VL; r++) exp_q.push_back(ref_dot(VL * r));
        for (int r = 0; r < VL; r++) begin
            run_cycles(13, 64'h1, 64'h0, AW'(VL * r));
            d = first_done(13);
            got_q.push_back((d >= 0) ? lg_res[d] : 'x);
        end
        for (int r = 0; r < VL; r++) begin
            n_checks++;
            if (got_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL rows_result row=%0d got=%0d exp=%0d", r, got_q[r], exp_q[r]); end
        end
    endtask

    task automatic test_random();
        logic [2*DW-1:0] exp;
        int b;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < MEM; i++) w_mem[i] = DW'($urandom);
            for (int i = 0; i < VL; i++)  x_mem[i] = DW'($urandom);
            b   = (it % 4 == 0) ? (MEM - 1 - int'($urandom_range(0, VL - 2))) : int'($urandom_range(0, MEM - 1));
            exp = ref_dot(b);
            run_cycles(13, 64'h1, 64'h0, AW'(b));
            n_checks++;
            if (first_done(13) != 10 || lg_res[10] !== exp) begin
                n_fail++; $display("FAIL random_result it=%0d base=%0d lat=%0d got=%h exp=%h", it, b, first_done(13), lg_res[10], exp);
            end
            n_checks++;
            if (lg_wa[VL] !== AW'((b + VL - 1) % MEM)) begin
                n_fail++; $display("FAIL random_last_addr it=%0d got=%0d exp=%0d", it, lg_wa[VL], (b + VL - 1) % MEM);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) begin
            w_mem[i] = '0;
            x_mem[i] = '0;
        end
        test_reset();
        test_basic();
        test_base_offset();
        test_extreme();
        test_ignore_start();
        test_mid_reset();
        test_rows();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the width of all memory addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the width of each signed weight and input element.
REQ-003 SHALL have parameter VEC_LEN, default 8, meaning the number of elements per dot product (>=1).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port dp_start  in  1  one-cycle request pulse from the matmul controller.
REQ-007 SHALL have port dp_weight_base_addr  in  ADDR_WIDTH  weight row base, sampled with an accepted dp_start.
REQ-008 SHALL have port dp_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port dp_result  out  2*DATA_WIDTH  signed dot product, valid from dp_done until the next accepted dp_start.
REQ-010 SHALL have ports w_rd_en out 1, w_rd_addr out ADDR_WIDTH, w_rd_data in DATA_WIDTH signed: weight memory read port with 1-cycle synchronous read latency.
REQ-011 SHALL have ports x_rd_en out 1, x_rd_addr out ADDR_WIDTH, x_rd_data in DATA_WIDTH signed: input-vector memory read port with 1-cycle read latency.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-014 IDLE: dp_start=1 accepted -> latch base, clear accumulator, element index=0, go FETCH; cycle of acceptance = cycle 0.
REQ-015 FETCH: cycles 1..VEC_LEN assert w_rd_en=x_rd_en=1, w_rd_addr=base+k-1, x_rd_addr=k-1 (k=cycle number); after index VEC_LEN-1 go DRAIN.
REQ-016 Read data returned in cycle k+1 SHALL be accumulated at the end of that cycle via a one-bit valid pipeline flag aligned to read latency.
REQ-017 DRAIN: one cycle accumulating the last element, rd_en low, then go DONE.
REQ-018 DONE: dp_done=1 and dp_result=final sum for exactly one cycle (cycle VEC_LEN+2), then go IDLE.
REQ-019 Arithmetic: signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH product; accumulation modulo 2^(2*DATA_WIDTH), two's-complement wrap, no saturation.
REQ-020 w_rd_addr SHALL wrap modulo 2^ADDR_WIDTH if base+k-1 exceeds the range.
REQ-021 dp_start while not in IDLE (including DONE) SHALL be ignored: no restart, no extra dp_done, base unchanged.
REQ-022 rd_en SHALL be low in IDLE, DRAIN, DONE; addresses are don't-care when rd_en is low.
REQ-023 dp_result SHALL hold its value across IDLE and change only at DONE entry.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, dp_done=0, dp_result=0, busy=0, w_rd_en=x_rd_en=0, addresses=0, accumulator=0, index=0, valid flag=0.
REQ-025 Reset mid-operation SHALL abandon the computation with no dp_done; the first dp_start after release SHALL be accepted normally.

Structure
REQ-026 The state enum dp_state_t SHALL live in shared package matmul_pkg alongside the controller's shared types.
REQ-027 Multiply-accumulate SHALL be a sub-module mac_unit (inputs: clear, enable, a, b; output: acc), instantiated once.

Verification (VEC_LEN=8, DATA_WIDTH=16)
REQ-028 w[0..7]=1..8, x[0..7]=1, base=0, start -> dp_result=36, dp_done exactly 10 cycles after the start cycle, busy high cycles 1..10.
REQ-029 base=8, w[8..15]=-2, x[0..7]=3..10 -> w_rd_addr 8..15, x_rd_addr 0..7 on consecutive cycles, dp_result=-104 (0xFFFFFF98).
REQ-030 All w=x=-32768 -> each product 2^30, sum 2^33 wraps -> dp_result=0.
REQ-031 Extra dp_start pulses in cycles 3 and 10 -> single dp_done, dp_result=36, no re-fetch.
REQ-032 rst_n low in cycle 4 -> rd_en=0 and dp_result=0 that cycle, no dp_done; new start after release -> 36 at latency 10.
REQ-033 Controller-paced 8-row run (start, done, 2-cycle gap) with w row r = r+1, x=1 -> results 8,16,...,64 in order.
